// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
// Shared constants for the MIPS pipeline stage registers: the bubble
// instruction word, MEM-stage control/payload widths and the control
// bit positions within the MEM-stage ctrl field.
package mips_pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // MEM-stage control field: {syscall, RegWrite, MemtoReg, MemWrite}
    localparam int MEM_CTRL_W = 4;
    localparam int SYSCALL    = 3;
    localparam int REGWRITE   = 2;
    localparam int MEMTOREG   = 1;
    localparam int MEMWRITE   = 0;

    // MEM-stage payload: {aluout, writeData, writeReg, a0, v0}
    localparam int ALUOUT_W    = 32;
    localparam int WRDATA_W    = 32;
    localparam int WRREG_W     = 5;
    localparam int A0_W        = 32;
    localparam int V0_W        = 32;
    localparam int MEM_DATA_W  = ALUOUT_W + WRDATA_W + WRREG_W + A0_W + V0_W;

endpackage

// File: rtl/pipe_perf_ctr.sv
// pipe_perf_ctr
// One saturating performance counter with synchronous clear.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears the count
//   clr   - synchronous clear, wins over inc
//   inc   - count this edge
//   count - current value, sticks at all-ones
module pipe_perf_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Generic pipeline stage register (used for the MEM stage) with stall
// hold, flush-to-bubble and optional stall/bubble performance counters.
// Edge priority: rst > flush > stall > load.
// Optional feature: define PIPE_STAGE_PERF_EN to build the counters;
// otherwise stall_cnt/bubble_cnt read 0 and perf_clr is ignored.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   stall, flush             - hold contents / load a bubble
//   valid_in, ctrl_in,
//   data_in, instr_in        - upstream stage contents
//   valid_out, ctrl_out,
//   data_out, instr_out      - registered stage contents
//   haz_ctrl_out             - duplicate ctrl register for the hazard unit
//   perf_clr                 - synchronous clear of both counters
//   stall_cnt, bubble_cnt    - saturating counts of stalls / bubbles
module pipe_stage_reg
    import mips_pipe_pkg::*;
#(
    parameter int CTRL_W = MEM_CTRL_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [31:0]       instr_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [31:0]       instr_out,
    output logic [CTRL_W-1:0] haz_ctrl_out,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // A non-valid load still carries data_in; only the control side is squashed.
    logic [CTRL_W-1:0] ctrl_load;
    logic [31:0]       instr_load;

    assign ctrl_load  = valid_in ? ctrl_in  : '0;
    assign instr_load = valid_in ? instr_in : NOP_INSTR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            data_out  <= '0;
            instr_out <= NOP_INSTR;
        end else if (flush) begin
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            data_out  <= '0;
            instr_out <= NOP_INSTR;
        end else if (!stall) begin
            valid_out <= valid_in;
            ctrl_out  <= ctrl_load;
            data_out  <= data_in;
            instr_out <= instr_load;
        end
    end

    // Separate flop bank so the hazard unit's fanout stays off ctrl_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haz_ctrl_out <= '0;
        end else if (flush) begin
            haz_ctrl_out <= '0;
        end else if (!stall) begin
            haz_ctrl_out <= ctrl_load;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = stall & ~flush;
    // A load with valid_in=0 also leaves a bubble in the stage.
    assign bubble_inc = flush | (~stall & ~valid_in);

    pipe_perf_ctr #(.W(CNT_W)) u_stall_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    pipe_perf_ctr #(.W(CNT_W)) u_bubble_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );
`else
    logic unused_perf_clr;

    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
    assign bubble_cnt      = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 4: control-bit field width (syscall, RegWrite, MemtoReg, MemWrite in the MEM-stage instance).
REQ-002 Parameter DATA_W, default 133: concatenated datapath payload width (aluout, writeData, writeReg, a0, v0).
REQ-003 Parameter CNT_W, default 16: performance-counter width.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: reset; one clock domain; reset is asynchronous and active-high.
REQ-006 Port stall, input, 1: hold the current stage contents.
REQ-007 Port flush, input, 1: replace the stage contents with a bubble.
REQ-008 Port valid_in, input, 1: the upstream stage holds a real instruction.
REQ-009 Port ctrl_in, input, CTRL_W: upstream control bits.
REQ-010 Port data_in, input, DATA_W: upstream payload.
REQ-011 Port instr_in, input, 32: upstream instruction word.
REQ-012 Port valid_out, output, 1: the stage holds a real instruction.
REQ-013 Port ctrl_out, output, CTRL_W: registered control bits, zero whenever valid_out=0.
REQ-014 Port data_out, output, DATA_W: registered payload.
REQ-015 Port instr_out, output, 32: registered instruction word.
REQ-016 Port haz_ctrl_out, output, CTRL_W: a separate registered copy of ctrl_out for the hazard unit, identical every cycle.
REQ-017 Port perf_clr, input, 1: synchronous counter clear.
REQ-018 Port stall_cnt, output, CNT_W: count of stalled cycles.
REQ-019 Port bubble_cnt, output, CNT_W: count of bubbles loaded.

Function
REQ-020 Latency SHALL be one clock: an input sampled at edge N appears on the outputs after edge N.
REQ-021 Priority at each edge SHALL be rst > flush > stall > load.
REQ-022 On flush=1: valid_out=0, ctrl_out=0, haz_ctrl_out=0, data_out=0, instr_out=NOP_INSTR, regardless of stall.
REQ-023 On stall=1 with flush=0: every output register SHALL hold its value.
REQ-024 On load with valid_in=1: the outputs SHALL take valid_in, ctrl_in, data_in and instr_in.
REQ-025 On load with valid_in=0: valid_out=0, ctrl_out=haz_ctrl_out=0, instr_out=NOP_INSTR, and data_out SHALL take data_in.
REQ-026 Every field SHALL be registered from its own input; no output SHALL feed back to itself except through the stall hold.
REQ-027 stall_cnt SHALL increment on each edge with stall=1 and flush=0.
REQ-028 bubble_cnt SHALL increment on each edge with flush=1, or on a load with valid_in=0.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 perf_clr=1 SHALL zero both counters at the edge, taking precedence over any increment that edge.

Reset
REQ-031 Asserting rst SHALL immediately, without a clock, force valid_out=0, ctrl_out=0, haz_ctrl_out=0, data_out=0, instr_out=NOP_INSTR, stall_cnt=0 and bubble_cnt=0.
REQ-032 Asserting rst mid-stall SHALL discard the held contents; the first edge after release SHALL follow REQ-021.

Configuration
REQ-033 Macro PIPE_STAGE_PERF_EN SHALL compile the counters in.
REQ-034 Without PIPE_STAGE_PERF_EN: the ports remain, stall_cnt and bubble_cnt are tied to 0, perf_clr is ignored, and no counter flops exist.

Structure
REQ-035 Package mips_pipe_pkg SHALL hold NOP_INSTR (32'h00000000), the MEM-stage CTRL_W and DATA_W constants, and the ctrl bit-index constants (SYSCALL, REGWRITE, MEMTOREG, MEMWRITE).
REQ-036 Sub-module pipe_perf_ctr SHALL implement one saturating, clearable counter, instantiated twice under PIPE_STAGE_PERF_EN.

Verification
REQ-037 Load: valid_in=1, ctrl_in=4'b0110, instr_in=32'h8C880004, then one edge -> identical outputs and haz_ctrl_out=4'b0110.
REQ-038 Stall: a 3-cycle stall with changing inputs -> outputs unchanged; stall_cnt=3.
REQ-039 Flush with stall: flush=1, stall=1 at the same edge -> valid_out=0, ctrl_out=0, instr_out=0; bubble_cnt=1, stall_cnt unchanged.
REQ-040 Async reset: rst pulsed between edges while outputs are nonzero -> all outputs 0 before the next edge.
REQ-041 Saturation: CNT_W=4 with 20 stall cycles -> stall_cnt=4'hF; perf_clr with stall=1 -> 0.
REQ-042 Macro off: 10 stalls and 5 flushes -> stall_cnt=bubble_cnt=0, and the datapath behaves identically to the macro-on build.
